// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen
//   Upstream control for the butterfly unit. Runs one in-place N-point transform
//   (NTT with Cooley-Tukey butterflies, op 2'b00, or INTT with Gentleman-Sande
//   butterflies, op 2'b01), issuing one butterfly per cycle: two coefficient read
//   addresses, a twiddle address and the op code. The matching write-back addresses
//   come out LAT = MEM_LAT + BFU_LAT cycles later to line up with the RAM read
//   latency plus the BFU pipeline.
//
// Ports
//   clk       clock, rising edge
//   rstn      synchronous active-low reset
//   start     begin a transform (sampled only when idle)
//   mode      0: NTT, 1: INTT; latched at start
//   stall     while running: hold the counters and issue nothing this cycle
//   busy      transform in progress (issuing or draining)
//   done      one-cycle completion pulse
//   op        BFU op code, held from start until the next start
//   rd_en     a butterfly is issued this cycle
//   rd_addr0  top-leg coefficient address
//   rd_addr1  bottom-leg coefficient address
//   tw_addr   twiddle ROM address
//   wr_en     rd_en delayed by LAT
//   wr_addr0  rd_addr0 delayed by LAT
//   wr_addr1  rd_addr1 delayed by LAT

module ntt_addr_gen #(
    parameter int unsigned LOGN    = 8,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned BFU_LAT = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            mode,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic [1:0]      op,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic [LOGN-1:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr0,
    output logic [LOGN-1:0] wr_addr1
);

    localparam int unsigned AW  = LOGN;
    localparam int unsigned N   = 1 << LOGN;
    localparam int unsigned LAT = MEM_LAT + BFU_LAT;
    localparam int unsigned SW  = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [AW-1:0] LastB = AW'(N / 2 - 1);
    localparam logic [SW-1:0] LastS = SW'(LOGN - 1);
    localparam logic [CW-1:0] LastC = CW'(LAT - 1);
    localparam logic [AW-1:0] AllOnes = AW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
    } dl_t;

    state_e        state_q;
    logic          mode_q;
    logic [SW-1:0] s_q;
    logic [AW-1:0] b_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          rd_en_q;
    logic [AW-1:0] rd_addr0_q;
    logic [AW-1:0] rd_addr1_q;
    logic [AW-1:0] tw_addr_q;
    dl_t           dl_q [LAT];

    // Butterfly address decode for the current (s, b)
    logic [SW-1:0] h;
    logic [AW-1:0] len;
    logic [AW-1:0] grp;
    logic [AW-1:0] off;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] tw;

    always_comb begin
        h   = mode_q ? s_q : LastS - s_q;
        len = AW'(1) << h;
        grp = b_q >> h;
        off = b_q & (len - AW'(1));
        // Two shifts so h+1 never overflows the SW-bit shift amount
        a0  = ((grp << h) << 1) | off;
        a1  = a0 + len;
        // (N>>s)-1 equals (N-1)>>s for a power-of-two N, keeping the math in AW bits
        tw  = mode_q ? ((AllOnes >> s_q) - grp) : ((AW'(1) << s_q) + grp);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            s_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            tw_addr_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q  <= mode;
                        s_q     <= '0;
                        b_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        rd_en_q    <= 1'b1;
                        rd_addr0_q <= a0;
                        rd_addr1_q <= a1;
                        tw_addr_q  <= tw;
                        if (b_q == LastB) begin
                            cnt_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            b_q <= b_q + AW'(1);
                        end
                    end
                end
                StDrain: begin
                    // Wait until the stage's last write-back has landed
                    if (cnt_q == LastC) begin
                        if (s_q == LastS) begin
                            busy_q  <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            s_q     <= s_q + SW'(1);
                            b_q     <= '0;
                            state_q <= StRun;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write-back delay line; shifts every cycle so stall bubbles show as wr_en=0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(LAT); i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= {rd_en_q, rd_addr0_q, rd_addr1_q};
            for (int i = 1; i < int'(LAT); i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign op       = {1'b0, mode_q};
    assign rd_en    = rd_en_q;
    assign rd_addr0 = rd_addr0_q;
    assign rd_addr1 = rd_addr1_q;
    assign tw_addr  = tw_addr_q;
    assign wr_en    = dl_q[LAT-1].en;
    assign wr_addr0 = dl_q[LAT-1].a0;
    assign wr_addr1 = dl_q[LAT-1].a1;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen at LOGN=3, LAT=9. Stimulus pushes expected read, write
// and done events (with absolute cycle numbers) into queues; a negedge monitor
// pops and compares whenever the DUT presents rd_en, wr_en or done.

module tb_ntt_addr_gen;

    localparam int unsigned LOGN    = 3;
    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned BFU_LAT = 8;
    localparam int LAT   = 9;
    localparam int STAGE = 13;   // N/2 + LAT
    localparam int DONEC = 40;   // LOGN*STAGE + 1

    logic            clk;
    logic            rstn;
    logic            start;
    logic            mode;
    logic            stall;
    logic            busy;
    logic            done;
    logic [1:0]      op;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr0;
    logic [LOGN-1:0] rd_addr1;
    logic [LOGN-1:0] tw_addr;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr0;
    logic [LOGN-1:0] wr_addr1;

    ntt_addr_gen #(
        .LOGN    (LOGN),
        .MEM_LAT (MEM_LAT),
        .BFU_LAT (BFU_LAT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .mode     (mode),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .op       (op),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_addr  (tw_addr),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    typedef struct {
        int a0;
        int a1;
        int tw;
        int cyc;
        int op;
    } exp_t;

    exp_t rdq[$];
    exp_t wrq[$];
    int   doneq[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   ntt_tab [12][3];
    int   intt_tab[12][3];
    int   t0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Queue expectations for a run whose start is sampled at the next edge
    task automatic launch(input bit m, input int n_rd, input int n_wr, input bit exp_done,
                          input int stall_at, input int stall_len, output int t_start);
        int   c;
        exp_t e;
        t_start = edge_cnt + 1;
        for (int i = 0; i < 12; i++) begin
            c = 1 + (i / 4) * STAGE + (i % 4);
            if (stall_at >= 0 && c > stall_at) c += stall_len;
            e.a0  = m ? intt_tab[i][0] : ntt_tab[i][0];
            e.a1  = m ? intt_tab[i][1] : ntt_tab[i][1];
            e.tw  = m ? intt_tab[i][2] : ntt_tab[i][2];
            e.op  = m ? 1 : 0;
            e.cyc = t_start + c;
            if (i < n_rd) rdq.push_back(e);
            e.cyc = t_start + c + LAT;
            if (i < n_wr) wrq.push_back(e);
        end
        if (exp_done) doneq.push_back(t_start + DONEC + stall_len);
        mode  = m;
        start = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_op"}, int'(op), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr0"}, int'(rd_addr0), 0);
        chk({tag, "_rd_addr1"}, int'(rd_addr1), 0);
        chk({tag, "_tw_addr"}, int'(tw_addr), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr0"}, int'(wr_addr0), 0);
        chk({tag, "_wr_addr1"}, int'(wr_addr1), 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rd_en) begin
            if (rdq.size() == 0) begin
                chk("rd_unexpected", edge_cnt, -1);
            end else begin
                e = rdq.pop_front();
                chk("rd_cycle", edge_cnt, e.cyc);
                chk("rd_addr0", int'(rd_addr0), e.a0);
                chk("rd_addr1", int'(rd_addr1), e.a1);
                chk("tw_addr", int'(tw_addr), e.tw);
                chk("op", int'(op), e.op);
            end
        end
        if (wr_en) begin
            if (wrq.size() == 0) begin
                chk("wr_unexpected", edge_cnt, -1);
            end else begin
                e = wrq.pop_front();
                chk("wr_cycle", edge_cnt, e.cyc);
                chk("wr_addr0", int'(wr_addr0), e.a0);
                chk("wr_addr1", int'(wr_addr1), e.a1);
            end
        end
        if (done) begin
            if (doneq.size() == 0) chk("done_unexpected", edge_cnt, -1);
            else                   chk("done_cycle", edge_cnt, doneq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ntt_tab = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1},
                    '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
                    '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};
        intt_tab = '{'{0,1,7}, '{2,3,6}, '{4,5,5}, '{6,7,4},
                     '{0,2,3}, '{1,3,3}, '{4,6,2}, '{5,7,2},
                     '{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1}};
        rstn  = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        stall = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rstn = 1'b1;
        step();
        step();

        // Run 1: NTT, no stall, start pulse while busy, start held into DONE
        launch(1'b0, 12, 12, 1'b1, -1, 0, t0);
        step();
        start = 1'b0;
        while (edge_cnt - t0 < DONEC - 1) begin
            step();
            start = (edge_cnt - t0 == 20);
        end
        chk("busy_in_done_state", int'(busy), 0);
        start = 1'b1;   // DONE-state cycle: must be ignored
        mode  = 1'b1;
        step();
        chk("done_pulse", int'(done), 1);

        // Run 2: back-to-back INTT accepted in first IDLE cycle, 3-cycle stall in stage 1
        launch(1'b1, 12, 12, 1'b1, 15, 3, t0);
        step();
        start = 1'b0;
        chk("busy_run", int'(busy), 1);
        chk("op_intt", int'(op), 1);
        while (edge_cnt - t0 < 50) begin
            step();
            stall = (edge_cnt - t0 >= 15) && (edge_cnt - t0 <= 17);
        end
        chk("busy_idle", int'(busy), 0);

        // Run 3: INTT aborted by reset in cycle 16
        launch(1'b1, 7, 4, 1'b0, -1, 0, t0);
        step();
        start = 1'b0;
        while (edge_cnt - t0 < 16) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk_all_zero("midreset");
        while (edge_cnt - t0 < 40) step();

        // Run 4: restart repeats the NTT run exactly
        launch(1'b0, 12, 12, 1'b1, -1, 0, t0);
        step();
        start = 1'b0;
        while (edge_cnt - t0 < 45) step();

        chk("rd_left", rdq.size(), 0);
        chk("wr_left", wrq.size(), 0);
        chk("done_left", doneq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
